mips_run_monitor: RTL and testbench
===================================

// Module: mips_run_monitor
// PURPOSE
//  Parametrised run-control/trace monitor that sits beside the MIPS core (main) in simulation and FPGA bring-up.
//  Samples the fetched instruction and ALU result every clk, counts cycles and retired non-NOP instructions,
//  raises halt after NOP_LIMIT consecutive NOPs or TIMEOUT_CYCLES cycles, and buffers an {instr,alu} trace in a FIFO.
//  Replaces fixed-time $finish and ad-hoc NOP counting in benches with a synthesizable, self-timed stop condition.
// PARAMETERS
//  DATA_W          32   width of instruction and alu_result
//  NOP_LIMIT       4    consecutive NOPs (instr==0) that trigger halt; legal 1..255
//  TIMEOUT_CYCLES  1024 cycles in RUN before forced halt; 0 disables timeout
//  TRACE_DEPTH     16   trace FIFO entries; power of two, >=2
//  CNT_W           32   width of cycle_count / instr_count
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          synchronous, active-low reset
//  enable         in   1          monitor counts/traces only while 1
//  instr          in   DATA_W     next_instruction from core
//  alu_result     in   DATA_W     alu_result from core
//  halt           out  1          1 = stop condition reached (sticky until reset)
//  halt_cause     out  2          mips_pkg::halt_cause_t: NONE=0, NOP=1, TIMEOUT=2
//  cycle_count    out  CNT_W      enabled cycles in RUN
//  instr_count    out  CNT_W      enabled non-NOP instructions in RUN
//  trace_valid    out  1          FIFO not empty
//  trace_ready    in   1          consumer pop request
//  trace_instr    out  DATA_W     head entry instruction
//  trace_alu      out  DATA_W     head entry alu_result
//  trace_overflow out  1          sticky: a push was dropped on full
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=RUN, halt=0, halt_cause=NONE, counters=0, nop_run=0,
//    FIFO empty (trace_valid=0, trace_instr/alu=0), trace_overflow=0. Reset mid-operation discards all trace data.
//  - FSM: RUN -> HALTED on stop condition; HALTED -> RUN only via reset. No other states.
//  - In RUN with enable=1, per cycle: cycle_count+=1; if instr==0 nop_run+=1 (saturating at NOP_LIMIT)
//    else {nop_run=0; instr_count+=1; push {instr,alu_result}}. enable=0: nothing changes, nop_run held.
//  - Stop: evaluated on the updated values; nop_run==NOP_LIMIT -> cause NOP; cycle_count==TIMEOUT_CYCLES
//    (TIMEOUT_CYCLES!=0) -> cause TIMEOUT; both in same cycle -> NOP wins. halt/halt_cause registered,
//    asserted the cycle after the triggering sample (latency 1).
//  - In HALTED: counters, nop_run, halt_cause frozen; no pushes; FIFO pops continue so trace drains.
//  - Counters wrap modulo 2^CNT_W (no saturation).
//  - FIFO: first-word-fall-through; trace_* show head combinationally from storage; pop when
//    trace_valid & trace_ready. Push when full and no pop: dropped, trace_overflow<=1.
//    Push and pop same cycle when full: both occur, no overflow. Pop when empty: ignored.
//  - Pointers are log2(TRACE_DEPTH)+1 bits; full/empty from MSB compare; wrap at TRACE_DEPTH.
// STRUCTURE
//  - mips_pkg: halt_cause_t enum (2 bits), NOP_INSTR = 32'h0000_0000, monitor state enum {RUN,HALTED}.
//  - Sub-module trace_fifo (params WIDTH=2*DATA_W, DEPTH=TRACE_DEPTH; push/pop/full/empty/overflow).
//  - Top holds FSM, nop_run counter, cycle/instr counters, stop-condition logic.
// TESTING
//  1. Core program: addi,addi,3xNOP,add,sub,and,or,sw,3xNOP,lw then NOPs, NOP_LIMIT=4 -> halt=1 cause=NOP
//     one cycle after 4th trailing NOP; instr_count=8; 3-NOP gaps do not halt.
//  2. TIMEOUT_CYCLES=10, instr stream of 32'h2000_000a forever -> halt at cycle 11, cause=TIMEOUT, cycle_count=10.
//  3. Same cycle 4th NOP and cycle_count==TIMEOUT_CYCLES -> cause=NOP.
//  4. TRACE_DEPTH=4, trace_ready=0, 6 non-NOPs -> trace_valid=1, 4 entries, trace_overflow=1; then
//     ready=1 -> first 4 instrs pop in order, trace_valid=0 after 4th.
//  5. Full FIFO, push+pop same cycle -> count stays 4, overflow stays 0, order preserved.
//  6. reset=0 for one cycle mid-run (halt=1, FIFO holding 3) -> next cycle all outputs at reset values;
//     enable=0 for 5 cycles afterwards -> cycle_count stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS run-control monitor.
package mips_pkg;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_NOP     = 2'd1,
        HC_TIMEOUT = 2'd2
    } halt_cause_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } mon_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO with sticky overflow flag.
module trace_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             overflow_q;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is masked while empty so a drained FIFO shows zero like after reset.
    assign rdata    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && full && !do_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Run-control monitor: counts cycles/instructions, halts on NOP run or timeout, buffers a trace.
module mips_run_monitor
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NOP_LIMIT      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] alu_result,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [DATA_W-1:0] trace_instr,
    output logic [DATA_W-1:0] trace_alu,
    output logic              trace_overflow
);

    localparam int unsigned NOP_W = 8;
    localparam int unsigned TW    = 2 * DATA_W;

    mon_state_t        state_q, state_d;
    logic              halt_q, halt_d;
    halt_cause_t       cause_q, cause_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [NOP_W-1:0]  nop_q, nop_d;
    logic              push_c;
    logic              fifo_empty;
    logic [TW-1:0]     fifo_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            halt_q  <= 1'b0;
            cause_q <= HC_NONE;
            cycle_q <= '0;
            instr_q <= '0;
            nop_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            cause_q <= cause_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
            nop_q   <= nop_d;
        end
    end

    // Stop conditions look at the post-update counters; a NOP run outranks a timeout.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        cause_d = cause_q;
        cycle_d = cycle_q;
        instr_d = instr_q;
        nop_d   = nop_q;
        push_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (enable) begin
                    cycle_d = cycle_q + CNT_W'(1);
                    if (instr == DATA_W'(NOP_INSTR)) begin
                        if (nop_q != NOP_W'(NOP_LIMIT)) begin
                            nop_d = nop_q + NOP_W'(1);
                        end
                    end else begin
                        nop_d   = '0;
                        instr_d = instr_q + CNT_W'(1);
                        push_c  = 1'b1;
                    end
                    if (nop_d == NOP_W'(NOP_LIMIT)) begin
                        state_d = ST_HALTED;
                        halt_d  = 1'b1;
                        cause_d = HC_NOP;
                    end else if ((TIMEOUT_CYCLES != 0) && (cycle_d == CNT_W'(TIMEOUT_CYCLES))) begin
                        state_d = ST_HALTED;
                        halt_d  = 1'b1;
                        cause_d = HC_TIMEOUT;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_c),
        .pop      (trace_ready),
        .wdata    ({instr, alu_result}),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .overflow (trace_overflow)
    );

    assign halt        = halt_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign trace_valid = !fifo_empty;
    assign trace_instr = fifo_rdata[TW-1:DATA_W];
    assign trace_alu   = fifo_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench: queue-based reference model plus directed program/FIFO scenarios.
module tb_mips_run_monitor;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NOP_LIM = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] instr = '0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              trace_ready = 1'b0;
    logic              halt;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instr_count;
    logic              trace_valid;
    logic [DATA_W-1:0] trace_instr;
    logic [DATA_W-1:0] trace_alu;
    logic              trace_overflow;

    mips_run_monitor #(
        .DATA_W         (DATA_W),
        .NOP_LIMIT      (NOP_LIM),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TRACE_DEPTH    (DEPTH),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .instr          (instr),
        .alu_result     (alu_result),
        .halt           (halt),
        .halt_cause     (halt_cause),
        .cycle_count    (cycle_count),
        .instr_count    (instr_count),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_instr    (trace_instr),
        .trace_alu      (trace_alu),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          live = 1'b0;
    bit          m_halted;
    int          m_cause;
    logic [31:0] m_cyc;
    logic [31:0] m_ic;
    int          m_nop;
    bit          m_ovf;
    logic [63:0] m_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit do_pop;
        bit do_push;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (!reset) begin
            m_halted = 1'b0;
            m_cause  = 0;
            m_cyc    = '0;
            m_ic     = '0;
            m_nop    = 0;
            m_ovf    = 1'b0;
            m_q.delete();
            live     = 1'b1;
        end else begin
            do_pop = (m_q.size() != 0) && trace_ready;
            if (!m_halted && enable) begin
                m_cyc = m_cyc + 1;
                if (instr == 0) begin
                    if (m_nop < int'(NOP_LIM)) m_nop++;
                end else begin
                    m_nop   = 0;
                    m_ic    = m_ic + 1;
                    do_push = 1'b1;
                end
                if (m_nop == int'(NOP_LIM)) begin
                    m_halted = 1'b1;
                    m_cause  = 1;
                end else if (TIMEOUT != 0 && m_cyc == TIMEOUT) begin
                    m_halted = 1'b1;
                    m_cause  = 2;
                end
            end
            if (do_push && m_q.size() == int'(DEPTH) && !do_pop) begin
                m_ovf = 1'b1;
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) m_q.push_back({instr, alu_result});
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 64'h0;
        check("halt", 64'(halt), 64'(m_halted));
        check("halt_cause", 64'(halt_cause), 64'(m_cause));
        check("cycle_count", 64'(cycle_count), 64'(m_cyc));
        check("instr_count", 64'(instr_count), 64'(m_ic));
        check("trace_valid", 64'(trace_valid), 64'(m_q.size() != 0));
        check("trace_instr", 64'(trace_instr), 64'(head[63:32]));
        check("trace_alu", 64'(trace_alu), 64'(head[31:0]));
        check("trace_overflow", 64'(trace_overflow), 64'(m_ovf));
    endtask

    // Model advances on the same edge the DUT samples; outputs compared just after.
    always @(posedge clk) begin
        model_step();
        #1;
        if (live) compare_all();
    end

    // Called at a negedge: apply inputs, return at the next negedge with outputs updated.
    task automatic drive(input logic rst_v, input logic en_v, input logic [31:0] ins,
                         input logic [31:0] alu_v, input logic rdy);
        reset       = rst_v;
        enable      = en_v;
        instr       = ins;
        alu_result  = alu_v;
        trace_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    logic [31:0] prog [18];

    initial begin
        prog[0]  = 32'h2001_0005; prog[1]  = 32'h2002_0003;
        prog[2]  = 32'h0;         prog[3]  = 32'h0;         prog[4] = 32'h0;
        prog[5]  = 32'h0022_1820; prog[6]  = 32'h0022_2022;
        prog[7]  = 32'h0022_2824; prog[8]  = 32'h0022_3025; prog[9] = 32'hAC03_0000;
        prog[10] = 32'h0;         prog[11] = 32'h0;         prog[12] = 32'h0;
        prog[13] = 32'h8C04_0000;
        prog[14] = 32'h0; prog[15] = 32'h0; prog[16] = 32'h0; prog[17] = 32'h0;

        @(negedge clk);
        do_reset();
        check("reset_halt", 64'(halt), 64'd0);
        check("reset_cycle", 64'(cycle_count), 64'd0);
        check("reset_valid", 64'(trace_valid), 64'd0);

        // Core program: 3-NOP gaps must not halt; the 4th trailing NOP does.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, prog[i], 32'(i * 3), 1'b1);
            if (i == 4 || i == 12) check("prog_gap_no_halt", 64'(halt), 64'd0);
            if (i == 16) check("prog_halt_pre", 64'(halt), 64'd0);
        end
        check("prog_halt", 64'(halt), 64'd1);
        check("prog_cause", 64'(halt_cause), 64'd1);
        check("prog_instr_count", 64'(instr_count), 64'd8);
        check("prog_cycle_count", 64'(cycle_count), 64'd18);

        // Timeout: non-NOP stream halts once cycle_count reaches TIMEOUT.
        do_reset();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            drive(1'b1, 1'b1, 32'h2000_000a, 32'(i), 1'b1);
            if (i == int'(TIMEOUT) - 2) check("to_pre", 64'(halt), 64'd0);
        end
        check("to_halt", 64'(halt), 64'd1);
        check("to_cause", 64'(halt_cause), 64'd2);
        check("to_cycle", 64'(cycle_count), 64'(TIMEOUT));
        drive(1'b1, 1'b1, 32'h2000_000a, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'h0, 32'h0, 1'b1);
        check("to_frozen", 64'(cycle_count), 64'(TIMEOUT));

        // NOP limit and timeout on the same sample: NOP wins.
        do_reset();
        for (int i = 0; i < int'(TIMEOUT) - int'(NOP_LIM); i++)
            drive(1'b1, 1'b1, 32'h1000 + 32'(i), 32'(i), 1'b1);
        for (int i = 0; i < int'(NOP_LIM); i++)
            drive(1'b1, 1'b1, 32'h0, 32'h0, 1'b1);
        check("tie_cause", 64'(halt_cause), 64'd1);
        check("tie_cycle", 64'(cycle_count), 64'(TIMEOUT));

        // Overflow: 6 pushes into a 4-deep FIFO, then drain in order.
        do_reset();
        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b1, 32'h100 + 32'(i), 32'hA0 + 32'(i), 1'b0);
        check("ovf_flag", 64'(trace_overflow), 64'd1);
        check("ovf_valid", 64'(trace_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("ovf_order", 64'(trace_instr), 64'(32'h100 + 32'(k)));
            check("ovf_alu", 64'(trace_alu), 64'(32'hA0 + 32'(k)));
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        check("ovf_drained", 64'(trace_valid), 64'd0);

        // Full FIFO with simultaneous push and pop: no overflow, order kept.
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 32'h200 + 32'(i), 32'(i), 1'b0);
        drive(1'b1, 1'b1, 32'h204, 32'h4, 1'b1);
        check("pp_no_ovf", 64'(trace_overflow), 64'd0);
        for (int k = 1; k < 5; k++) begin
            check("pp_order", 64'(trace_instr), 64'(32'h200 + 32'(k)));
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        check("pp_drained", 64'(trace_valid), 64'd0);

        // Mid-run reset while halted with 3 entries buffered.
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 32'h300 + 32'(i), 32'(i), 1'b0);
        for (int i = 0; i < int'(NOP_LIM); i++)
            drive(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        check("mr_halt", 64'(halt), 64'd1);
        check("mr_valid", 64'(trace_valid), 64'd1);
        do_reset();
        check("mr_rst_halt", 64'(halt), 64'd0);
        check("mr_rst_cause", 64'(halt_cause), 64'd0);
        check("mr_rst_valid", 64'(trace_valid), 64'd0);
        check("mr_rst_instr", 64'(trace_instr), 64'd0);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, $urandom, $urandom, 1'b1);
        check("mr_idle_cycle", 64'(cycle_count), 64'd0);
        check("mr_idle_instr", 64'(instr_count), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic        r_rst;
            logic        r_en;
            logic [31:0] r_ins;
            r_rst = ($urandom_range(0, 59) != 0);
            r_en  = ($urandom_range(0, 4) != 0);
            r_ins = ($urandom_range(0, 1) != 0) ? 32'h0 : $urandom;
            drive(r_rst, r_en, r_ins, $urandom, ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
